// File: rtl/piso_ser_ctrl.sv
// Sequencing controller for a PISO shift datapath: valid/ready word intake, MSB-first serial
// frame with start/end markers, and an idle gap between frames. PISO_SER_PARITY_EN appends even parity.
module piso_ser_ctrl #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             piso_load,
   output logic             piso_shift,
   output logic             busy
);

`ifdef PISO_SER_PARITY_EN
   localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
   localparam int unsigned FRAME_LEN = WIDTH;
`endif
   localparam int unsigned CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] sreg_q;
   logic [CW-1:0]    cnt_q;
   logic [3:0]       gap_q;
   logic             accept;
   logic             last_bit;
   logic             next_bit;

   assign in_ready  = rst && (state_q == StIdle);
   assign accept    = in_valid && in_ready;
   assign piso_load = accept;

   // cnt_q is the index of the frame bit currently on ser_out
   assign last_bit = (cnt_q == CW'(FRAME_LEN - 1));

`ifdef PISO_SER_PARITY_EN
   logic parity_q;
   assign next_bit = (cnt_q == CW'(WIDTH - 1)) ? parity_q : sreg_q[WIDTH-1];
`else
   assign next_bit = sreg_q[WIDTH-1];
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         sreg_q      <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
         ser_out     <= 1'b0;
         ser_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         piso_shift  <= 1'b0;
         busy        <= 1'b0;
`ifdef PISO_SER_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  state_q     <= StShift;
                  // MSB goes out straight away; the register keeps the remaining bits
                  sreg_q      <= in_data << 1;
                  cnt_q       <= '0;
                  ser_out     <= in_data[WIDTH-1];
                  ser_valid   <= 1'b1;
                  frame_start <= 1'b1;
                  frame_end   <= 1'b0;
                  piso_shift  <= 1'b1;
                  busy        <= 1'b1;
`ifdef PISO_SER_PARITY_EN
                  parity_q    <= ^in_data;
`endif
               end
            end
            StShift: begin
               frame_start <= 1'b0;
               if (last_bit) begin
                  ser_out    <= 1'b0;
                  ser_valid  <= 1'b0;
                  frame_end  <= 1'b0;
                  piso_shift <= 1'b0;
                  if (GAP_CYCLES > 0) begin
                     state_q <= StGap;
                     gap_q   <= 4'(GAP_CYCLES);
                     busy    <= 1'b1;
                  end else begin
                     state_q <= StIdle;
                     busy    <= 1'b0;
                  end
               end else begin
                  ser_out   <= next_bit;
                  sreg_q    <= sreg_q << 1;
                  cnt_q     <= cnt_q + CW'(1);
                  frame_end <= (cnt_q == CW'(FRAME_LEN - 2));
               end
            end
            StGap: begin
               if (gap_q <= 4'd1) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end else begin
                  gap_q <= gap_q - 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_ser_ctrl.sv
// Self-checking bench for piso_ser_ctrl: a GAP=1 instance driven from a vector table with a
// frame scoreboard, and a GAP=0 instance for the back-to-back handshake sequence.
module tb_piso_ser_ctrl;
   localparam int W = 4;
   localparam int GAP = 1;
`ifdef PISO_SER_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic in_ready, ser_out, ser_valid, frame_start, frame_end, piso_load, piso_shift, busy;

   logic in_valid_b = 1'b0;
   logic [W-1:0] in_data_b = '0;
   logic in_ready_b, ser_out_b, ser_valid_b, frame_start_b, frame_end_b;
   logic piso_load_b, piso_shift_b, busy_b;

   piso_ser_ctrl #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
      .frame_end(frame_end), .piso_load(piso_load), .piso_shift(piso_shift), .busy(busy)
   );

   piso_ser_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
      .ser_out(ser_out_b), .ser_valid(ser_valid_b), .frame_start(frame_start_b),
      .frame_end(frame_end_b), .piso_load(piso_load_b), .piso_shift(piso_shift_b),
      .busy(busy_b)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int npush = 0;
   int frames = 0;
   logic [FL-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [FL-1:0] frame_of(input logic [W-1:0] w);
`ifdef PISO_SER_PARITY_EN
      return {w, ^w};
`else
      return w;
`endif
   endfunction

   function automatic logic [5:0] outs();
      return {ser_out, ser_valid, frame_start, frame_end, piso_shift, busy};
   endfunction

   // Frame monitor: assembles bits of each frame and compares against the scoreboard queue
   initial begin
      logic [FL-1:0] got;
      logic [FL-1:0] want;
      int nbits;
      got = '0;
      nbits = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            nbits = 0;
         end else if (ser_valid) begin
            check("mon_frame_start", frame_start, nbits == 0);
            got = {got[FL-2:0], ser_out};
            nbits++;
            check("mon_frame_end", frame_end, nbits == FL);
            check("mon_shift", piso_shift, 1);
            if (nbits == FL) begin
               check("mon_queue_nonempty", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  want = exp_q.pop_front();
                  check("mon_frame_data", got, want);
               end
               nbits = 0;
               frames++;
            end
         end else begin
            check("mon_markers_idle", {frame_start, frame_end, piso_shift}, 0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] w, input bit noisy);
      logic [FL-1:0] f;
      f = frame_of(w);
      in_valid = 1'b1;
      in_data = w;
      #1;
      check("accept_ready", in_ready, 1);
      check("accept_load", piso_load, 1);
      check("accept_busy", busy, 0);
      exp_q.push_back(f);
      npush++;
      for (int k = 1; k <= FL + GAP; k++) begin
         cyc();
         if (noisy) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = W'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         check("busy_ready", in_ready, 0);
         check("busy_load", piso_load, 0);
         check("busy_flag", busy, 1);
         check("ser_valid", ser_valid, k <= FL);
         check("ser_out", ser_out, (k <= FL) ? f[FL-k] : 1'b0);
      end
      cyc();
      in_valid = 1'b0;
      #1;
      check("ready_after_frame", in_ready, 1);
   endtask

   typedef struct {
      logic [W-1:0] word;
      bit           noisy;
      int           idle;
   } vec_t;

   initial begin
      vec_t vecs[6];
      logic [FL-1:0] fa;
      logic [FL-1:0] fb;
      vecs[0] = '{word: 4'b1011, noisy: 1'b0, idle: 1};
      vecs[1] = '{word: 4'b0110, noisy: 1'b0, idle: 0};
      vecs[2] = '{word: 4'b0000, noisy: 1'b0, idle: 2};
      vecs[3] = '{word: 4'b1111, noisy: 1'b0, idle: 0};
      vecs[4] = '{word: 4'b1001, noisy: 1'b1, idle: 1};
      vecs[5] = '{word: 4'b0101, noisy: 1'b1, idle: 0};

      // Reset: ready and load held low even with a valid word waiting
      cyc();
      in_valid = 1'b1;
      in_data = 4'hF;
      #1;
      check("rst_ready", in_ready, 0);
      check("rst_load", piso_load, 0);
      cyc();
      check("rst_outs", outs(), 0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("post_rst_ready", in_ready, 1);
      check("post_rst_outs", outs(), 0);

      foreach (vecs[i]) begin
         for (int j = 0; j < vecs[i].idle; j++) begin
            cyc();
            #1;
            check("idle_ready", in_ready, 1);
            check("idle_load", piso_load, 0);
            check("idle_outs", outs(), 0);
         end
         send(vecs[i].word, vecs[i].noisy);
      end

      // Mid-frame reset: abort after two bits, then a clean frame
      in_valid = 1'b1;
      in_data = 4'b1100;
      #1;
      check("abort_load", piso_load, 1);
      cyc();
      in_valid = 1'b0;
      #1;
      check("abort_bit0", ser_out, 1);
      cyc();
      rst = 1'b0;
      #1;
      check("abort_bit1", ser_out, 1);
      cyc();
      check("abort_outs", outs(), 0);
      check("abort_ready", in_ready, 0);
      rst = 1'b1;
      #1;
      check("abort_ready_release", in_ready, 1);
      send(4'b0110, 1'b0);

      // GAP=0 instance: producer holds in_valid across two words
      cyc();
      fa = frame_of(4'hA);
      fb = frame_of(4'h5);
      in_valid_b = 1'b1;
      in_data_b = 4'hA;
      #1;
      check("b2b_accept_a", piso_load_b, 1);
      for (int k = 1; k <= FL; k++) begin
         cyc();
         in_data_b = 4'h5;
         #1;
         check("b2b_ready_a", in_ready_b, 0);
         check("b2b_valid_a", ser_valid_b, 1);
         check("b2b_bit_a", ser_out_b, fa[FL-k]);
         check("b2b_end_a", frame_end_b, k == FL);
      end
      cyc();
      check("b2b_accept_b", piso_load_b, 1);
      check("b2b_idle_gap", ser_valid_b, 0);
      for (int k = 1; k <= FL; k++) begin
         cyc();
         in_valid_b = 1'b0;
         #1;
         check("b2b_valid_b", ser_valid_b, 1);
         check("b2b_bit_b", ser_out_b, fb[FL-k]);
         check("b2b_start_b", frame_start_b, k == 1);
      end
      cyc();
      check("b2b_no_dup", {ser_valid_b, busy_b}, 0);
      check("b2b_ready_end", in_ready_b, 1);

      cyc();
      cyc();
      check("frames_seen", frames, npush);
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/piso_ser_ctrl.md
Name: piso_ser_ctrl

Overview:
- Sequencing controller for the 4-bit parallel-in/serial-out shift datapath.
- Accepts parallel words over a valid/ready handshake and owns the shift register internally.
- Emits the word MSB-first, one bit per clock, with frame markers and a configurable inter-word gap.
- Also drives load/shift strobes so an external PISO instance can be run in lockstep.

Parameters:
- WIDTH, 4, parallel word width in bits (legal range 2..32).
- GAP_CYCLES, 1, idle cycles inserted after each frame before the next word is accepted (legal range 0..15).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset
- in_valid  input  1  producer has a word on in_data
- in_data  input  WIDTH  parallel word to serialize
- in_ready  output  1  controller can accept a word this cycle
- ser_out  output  1  serial data bit, MSB first
- ser_valid  output  1  ser_out carries a frame bit this cycle
- frame_start  output  1  high with the first bit of a frame
- frame_end  output  1  high with the last bit of a frame
- piso_load  output  1  one-cycle strobe on the word-accept cycle
- piso_shift  output  1  high on every bit-output cycle
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: rst sampled low at a clk edge gives state=IDLE, shift register=0, bit counter=0.
  - Registered outputs go to 0: ser_out, ser_valid, frame_start, frame_end, piso_shift, busy.
  - While rst is low, in_ready and piso_load are forced to 0.
  - in_ready=1 on the first cycle after rst returns high.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1 combinationally.
  - Accept occurs when in_valid && in_ready at an edge, call it cycle T.
  - On accept: capture in_data into the shift register, clear the bit counter, assert piso_load during cycle T, go to SHIFT.
  - in_valid low: stay in IDLE with all outputs 0.
- SHIFT:
  - One frame bit per cycle, registered.
  - Bit k (k=0..FRAME_LEN-1) appears on ser_out in cycle T+1+k. FRAME_LEN=WIDTH without the option.
  - ser_valid=piso_shift=busy=1 throughout.
  - frame_start=1 only for k=0; frame_end=1 only for k=FRAME_LEN-1.
  - On the last bit: go to GAP if GAP_CYCLES>0, else to IDLE.
  - in_ready=0 throughout; in_data and in_valid are ignored.
- GAP:
  - Down-counter loaded with GAP_CYCLES.
  - busy=1; ser_valid=0; ser_out=0.
  - Return to IDLE when the counter expires.
- Timing:
  - First-bit latency from accept: 1 cycle.
  - Minimum accept-to-accept period: FRAME_LEN+GAP_CYCLES+1 cycles (the +1 is the IDLE accept cycle).
- Handshake rules:
  - The producer holds in_data and in_valid until it sees in_ready.
  - Deasserting in_valid before acceptance is legal; no word is taken.
  - Input changes during SHIFT or GAP have no effect on the frame in flight.
- Bit counter width is $clog2(WIDTH+2). It must not wrap within a frame.
- Reset mid-frame: the frame is aborted immediately with no further bits and no frame_end. The next frame starts cleanly after reset release.
- WIDTH=2 with GAP_CYCLES=0: frames are back-to-back apart from the single IDLE accept cycle.

Optional Feature:
- Macro PISO_SER_PARITY_EN.
- Defined:
  - FRAME_LEN=WIDTH+1.
  - An even-parity bit (XOR of all captured data bits) follows the data LSB.
  - frame_end moves to the parity bit.
  - Parity is computed from the captured word, not from live in_data.
- Undefined:
  - FRAME_LEN=WIDTH; no parity logic is instantiated.

Test Plan:
- Reset release, WIDTH=4, GAP=1 -> in_ready=1 on the first post-reset cycle; all other outputs 0; busy=0.
- Accept 4'b1011 at T -> ser_out=1,0,1,1 at T+1..T+4 with ser_valid=1, frame_start at T+1, frame_end at T+4, piso_load only at T; in_ready=0 for T+1..T+5 and 1 again at T+6.
- in_valid held high with 4'hA then 4'h5, GAP=0 -> bits 1010 at T+1..T+4, second accept at T+5, bits 0101 at T+6..T+9; no word dropped or duplicated.
- rst low at T+2 during frame 4'b1100 -> at T+3 all outputs 0, no frame_end; after release, a new word 4'b0110 serializes correctly.
- in_data toggled every cycle during SHIFT -> serialized bits match only the word captured at accept.
- PISO_SER_PARITY_EN defined, word 4'b1011 -> ser_out=1,0,1,1,1 at T+1..T+5, frame_end at T+5; word 4'b0110 gives parity bit 0.
